// File: rtl/mdu_sequencer_if.sv
// rtl/mdu_sequencer_if.sv - handshake bundle between the EX stage and the multiply/divide sequencer
//
// Signals (master = pipeline/EX stage, slave = mdu_sequencer):
//   start_E   master->slave  M-extension op present in EX (held while stalled)
//   op_E      master->slave  00 MUL, 01 MULHU, 10 DIVU, 11 REMU
//   src_a_E   master->slave  multiplicand / dividend (forwarded)
//   src_b_E   master->slave  multiplier / divisor (forwarded)
//   flush_E   master->slave  kill the EX op
//   stall_req slave->master  hold IF/ID/EX, bubble EX/MEM
//   busy      slave->master  sequencer not idle
//   valid_out slave->master  result valid this cycle
//   result    slave->master  selected result
interface mdu_sequencer_if #(
    parameter int XLEN = 64
);
    logic            start_E;
    logic [1:0]      op_E;
    logic [XLEN-1:0] src_a_E;
    logic [XLEN-1:0] src_b_E;
    logic            flush_E;
    logic            stall_req;
    logic            busy;
    logic            valid_out;
    logic [XLEN-1:0] result;

    modport master (
        output start_E, op_E, src_a_E, src_b_E, flush_E,
        input  stall_req, busy, valid_out, result
    );

    modport slave (
        input  start_E, op_E, src_a_E, src_b_E, flush_E,
        output stall_req, busy, valid_out, result
    );
endinterface

// File: rtl/mdu_sequencer.sv
// rtl/mdu_sequencer.sv - iterative RV64M unsigned multiply/divide sequencer beside the EX-stage ALU
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   bus  mdu_sequencer_if.slave (start_E, op_E, src_a_E, src_b_E, flush_E in;
//        stall_req, busy, valid_out, result out)
// Optional feature: define MDU_EARLY_OUT_EN to finish ops with a zero operand in
// two cycles by going straight from IDLE to DONE.
module mdu_sequencer #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input  logic           clk,
    input  logic           rst,
    mdu_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0]       OP_MUL   = 2'b00;
    localparam logic [1:0]       OP_MULHU = 2'b01;
    localparam logic [1:0]       OP_DIVU  = 2'b10;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    state_t            state;
    logic [CNT_W-1:0]  count;
    logic [1:0]        op_q;
    logic [XLEN-1:0]   opnd;     // multiplicand for MUL ops, divisor for DIV ops
    logic [XLEN-1:0]   mplr;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   quo;
    logic              busy_q;
    logic              valid_q;
    logic [XLEN-1:0]   result_q;

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] acc_next;
    logic [XLEN:0]     rem_shift;
    logic [XLEN:0]     trial;
    logic [XLEN-1:0]   rem_next;
    logic [XLEN-1:0]   quo_next;
    logic [XLEN-1:0]   done_result;

    // One iteration of both datapaths; op_q picks which one is meaningful at the end.
    always_comb begin
        // Carry out of the upper-half add lands in bit XLEN and is shifted back in.
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (mplr[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
        acc_next  = {mul_sum, acc[XLEN-1:1]};
        // rem < divisor always holds, so the shifted remainder fits in XLEN+1 bits.
        rem_shift = {rem, quo[XLEN-1]};
        trial     = rem_shift - {1'b0, opnd};
        if (!trial[XLEN]) begin
            rem_next = trial[XLEN-1:0];
            quo_next = {quo[XLEN-2:0], 1'b1};
        end else begin
            rem_next = rem_shift[XLEN-1:0];
            quo_next = {quo[XLEN-2:0], 1'b0};
        end
    end

    // Result of the final iteration, registered on the RUN->DONE edge.
    always_comb begin
        case (op_q)
            OP_MUL:   done_result = acc_next[XLEN-1:0];
            OP_MULHU: done_result = acc_next[2*XLEN-1:XLEN];
            OP_DIVU:  done_result = quo_next;
            default:  done_result = rem_next;
        endcase
    end

`ifdef MDU_EARLY_OUT_EN
    logic            early_zero;
    logic [XLEN-1:0] early_result;

    assign early_zero = (bus.src_a_E == '0) || (bus.src_b_E == '0);

    always_comb begin
        case (bus.op_E)
            OP_DIVU: early_result = (bus.src_b_E == '0) ? {XLEN{1'b1}} : '0;
            2'b11:   early_result = bus.src_a_E;
            default: early_result = '0;
        endcase
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            count    <= '0;
            op_q     <= OP_MUL;
            opnd     <= '0;
            mplr     <= '0;
            acc      <= '0;
            rem      <= '0;
            quo      <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start_E && !bus.flush_E) begin
                        op_q   <= bus.op_E;
                        opnd   <= bus.op_E[1] ? bus.src_b_E : bus.src_a_E;
                        mplr   <= bus.src_b_E;
                        acc    <= '0;
                        rem    <= '0;
                        quo    <= bus.src_a_E;
                        count  <= CNT_INIT;
                        busy_q <= 1'b1;
`ifdef MDU_EARLY_OUT_EN
                        if (early_zero) begin
                            state    <= DONE;
                            valid_q  <= 1'b1;
                            result_q <= early_result;
                        end else begin
                            state <= RUN;
                        end
`else
                        state <= RUN;
`endif
                    end
                end
                RUN: begin
                    if (bus.flush_E) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        acc   <= acc_next;
                        mplr  <= mplr >> 1;
                        rem   <= rem_next;
                        quo   <= quo_next;
                        count <= count - CNT_LAST;
                        if (count == CNT_LAST) begin
                            state    <= DONE;
                            valid_q  <= 1'b1;
                            result_q <= done_result;
                        end
                    end
                end
                DONE: begin
                    // The finishing instruction is still in EX this cycle, so start_E is ignored.
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    // Combinational so the start cycle itself stalls; low in DONE so EX/MEM captures the result.
    assign bus.stall_req = rst && (((state == IDLE) && bus.start_E && !bus.flush_E) || (state == RUN));
    assign bus.busy      = busy_q;
    assign bus.valid_out = valid_q;
    assign bus.result    = result_q;
endmodule
